// File: rtl/mcb_p0_responder.sv
// mcb_p0_responder: behavioural responder for one MCB user port (p0).
// Calibration timer, command / write / read FIFOs, a command executor
// and a word-addressed backing memory with byte-masked writes.
module mcb_p0_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        calib_done,
  input  logic        p0_cmd_en,
  input  logic [2:0]  p0_cmd_instr,
  input  logic [29:0] p0_cmd_byte_addr,
  input  logic [5:0]  p0_cmd_bl,
  output logic        p0_cmd_full,
  output logic        p0_cmd_empty,
  output logic        p0_cmd_error,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_wr_data,
  input  logic [3:0]  p0_wr_mask,
  output logic        p0_wr_full,
  output logic        p0_wr_empty,
  output logic [6:0]  p0_wr_count,
  output logic        p0_wr_error,
  output logic        p0_wr_underrun,
  input  logic        p0_rd_en,
  output logic [31:0] p0_rd_data,
  output logic        p0_rd_empty,
  output logic        p0_rd_full,
  output logic [6:0]  p0_rd_count,
  output logic        p0_rd_error
);

  localparam int CAL_W     = (CALIB_CYCLES < 2) ? 1 : $clog2(CALIB_CYCLES + 1);
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam int CMD_W     = 39;  // {instr[2:0], byte_addr[29:0], bl[5:0]}
  localparam logic [CAL_W-1:0]      CAL_LAST = CAL_W'(CALIB_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_READ      = 3'd4
  } state_t;

  // ---------------------------------------------------------------- calibration
  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic             calib_done_q, calib_done_d;

  // Count edges since reset release; done latches on the CALIB_CYCLES-th edge
  always_comb begin
    cal_cnt_d    = cal_cnt_q;
    calib_done_d = calib_done_q;
    if (!calib_done_q) begin
      cal_cnt_d    = cal_cnt_q + CAL_W'(1);
      calib_done_d = (cal_cnt_q == CAL_LAST);
    end else begin
      cal_cnt_d    = cal_cnt_q;
    end
  end

  // Calibration state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_cnt_q    <= '0;
      calib_done_q <= 1'b0;
    end else begin
      cal_cnt_q    <= cal_cnt_d;
      calib_done_q <= calib_done_d;
    end
  end

  // ---------------------------------------------------------------- command FIFO
  logic [CMD_W-1:0] cmd_mem_q [4];
  logic [1:0]       cmd_wptr_q, cmd_rptr_q;
  logic [2:0]       cmd_cnt_q;
  logic             cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;

  // Commands are refused until calibration completes
  assign cmd_full_s  = !calib_done_q || (cmd_cnt_q == 3'd4);
  assign cmd_empty_s = (cmd_cnt_q == 3'd0);
  assign cmd_push_s  = p0_cmd_en && !cmd_full_s;

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_wptr_q <= 2'd0;
      cmd_rptr_q <= 2'd0;
      cmd_cnt_q  <= 3'd0;
    end else begin
      if (cmd_push_s) cmd_wptr_q <= cmd_wptr_q + 2'd1;
      if (cmd_pop_s)  cmd_rptr_q <= cmd_rptr_q + 2'd1;
      cmd_cnt_q <= cmd_cnt_q + {2'd0, cmd_push_s} - {2'd0, cmd_pop_s};
    end
  end

  // Command FIFO storage; occupancy qualifies every read so no reset is needed
  always_ff @(posedge clk) begin
    if (cmd_push_s) cmd_mem_q[cmd_wptr_q] <= {p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl};
  end

  // ---------------------------------------------------------------- write FIFO
  logic [35:0] wr_mem_q [64];
  logic [5:0]  wr_wptr_q, wr_rptr_q;
  logic [6:0]  wr_cnt_q;
  logic        wr_full_s, wr_empty_s, wr_push_s, wr_pop_s;
  logic [35:0] wr_head_s;

  assign wr_full_s  = (wr_cnt_q == 7'd64);
  assign wr_empty_s = (wr_cnt_q == 7'd0);
  assign wr_push_s  = p0_wr_en && !wr_full_s;
  assign wr_head_s  = wr_mem_q[wr_rptr_q];

  // Write FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_wptr_q <= 6'd0;
      wr_rptr_q <= 6'd0;
      wr_cnt_q  <= 7'd0;
    end else begin
      if (wr_push_s) wr_wptr_q <= wr_wptr_q + 6'd1;
      if (wr_pop_s)  wr_rptr_q <= wr_rptr_q + 6'd1;
      wr_cnt_q <= wr_cnt_q + {6'd0, wr_push_s} - {6'd0, wr_pop_s};
    end
  end

  // Write FIFO storage: {mask, data}
  always_ff @(posedge clk) begin
    if (wr_push_s) wr_mem_q[wr_wptr_q] <= {p0_wr_mask, p0_wr_data};
  end

  // ---------------------------------------------------------------- read FIFO
  logic [31:0] rd_mem_q [64];
  logic [5:0]  rd_wptr_q, rd_rptr_q;
  logic [6:0]  rd_cnt_q;
  logic        rd_empty_s, rd_pop_s, rd_valid_q;
  logic [31:0] mem_rdata_q;

  assign rd_empty_s = (rd_cnt_q == 7'd0);
  assign rd_pop_s   = p0_rd_en && !rd_empty_s;

  // Read FIFO pointers and occupancy; pushes come from the memory read stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wptr_q <= 6'd0;
      rd_rptr_q <= 6'd0;
      rd_cnt_q  <= 7'd0;
    end else begin
      if (rd_valid_q) rd_wptr_q <= rd_wptr_q + 6'd1;
      if (rd_pop_s)   rd_rptr_q <= rd_rptr_q + 6'd1;
      rd_cnt_q <= rd_cnt_q + {6'd0, rd_valid_q} - {6'd0, rd_pop_s};
    end
  end

  // Read FIFO storage
  always_ff @(posedge clk) begin
    if (rd_valid_q) rd_mem_q[rd_wptr_q] <= mem_rdata_q;
  end

  // ---------------------------------------------------------------- executor
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [6:0]            rem_q, rem_d;
  logic [CMD_W-1:0]      cur_cmd_q, cur_cmd_d;
  logic                  mem_we_s, rd_issue_s, rd_room_s;
  logic [7:0]            rd_need_s;
  logic [2:0]            cur_instr_s;
  logic [29:0]           cur_addr_s;
  logic [5:0]            cur_bl_s;

  assign cur_instr_s = cur_cmd_q[38:36];
  assign cur_addr_s  = cur_cmd_q[35:6];
  assign cur_bl_s    = cur_cmd_q[5:0];

  // A burst may start only if every word, plus anything already in flight, fits
  assign rd_need_s = {1'b0, rd_cnt_q} + {7'd0, rd_valid_q} + {1'b0, rem_q};
  assign rd_room_s = (rd_need_s <= 8'd64);

  // Executor next-state and datapath control
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    cur_cmd_d  = cur_cmd_q;
    cmd_pop_s  = 1'b0;
    wr_pop_s   = 1'b0;
    mem_we_s   = 1'b0;
    rd_issue_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty_s) begin
          cmd_pop_s = 1'b1;
          cur_cmd_d = cmd_mem_q[cmd_rptr_q];
          state_d   = ST_DECODE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_DECODE: begin
        ptr_d = cur_addr_s[ADDR_WIDTH+1:2];
        rem_d = {1'b0, cur_bl_s} + 7'd1;
        if (cur_instr_s[2]) begin
          state_d = ST_IDLE;
        end else if (!cur_instr_s[0]) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_WRITE: begin
        if (!wr_empty_s) begin
          wr_pop_s = 1'b1;
          mem_we_s = 1'b1;
          ptr_d    = ptr_q + PTR_ONE;
          rem_d    = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ_WAIT: begin
        // The first read is issued on the same edge that enters READ
        if (rd_room_s) begin
          rd_issue_s = 1'b1;
          ptr_d      = ptr_q + PTR_ONE;
          rem_d      = rem_q - 7'd1;
          state_d    = ST_READ;
        end else begin
          state_d    = ST_READ_WAIT;
        end
      end
      ST_READ: begin
        if (rem_q != 7'd0) begin
          rd_issue_s = 1'b1;
          ptr_d      = ptr_q + PTR_ONE;
          rem_d      = rem_q - 7'd1;
          state_d    = ST_READ;
        end else begin
          // The last word is pushed into the read FIFO on this edge
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Executor registers; reset aborts any burst in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= 7'd0;
      cur_cmd_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      cur_cmd_q  <= cur_cmd_d;
      rd_valid_q <= rd_issue_s;
    end
  end

  // ---------------------------------------------------------------- backing memory
  logic [31:0] mem_q [MEM_WORDS];

  // Byte-masked write (mask bit 1 keeps the old byte) and synchronous read
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head_s[32+b]) mem_q[ptr_q][8*b +: 8] <= wr_head_s[8*b +: 8];
      end
    end
    if (rd_issue_s) mem_rdata_q <= mem_q[ptr_q];
  end

  // ---------------------------------------------------------------- status / errors
  logic cmd_error_q, wr_error_q, rd_error_q;

  // One-cycle error pulses for refused pushes and pops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_error_q <= 1'b0;
      wr_error_q  <= 1'b0;
      rd_error_q  <= 1'b0;
    end else begin
      cmd_error_q <= p0_cmd_en && cmd_full_s;
      wr_error_q  <= p0_wr_en && wr_full_s;
      rd_error_q  <= p0_rd_en && rd_empty_s;
    end
  end

  // Address bits outside the word index and the unused instruction bit
  logic unused_s;
  assign unused_s = ^{cur_instr_s[1], cur_addr_s[29:ADDR_WIDTH+2], cur_addr_s[1:0]};

  assign calib_done     = calib_done_q;
  assign p0_cmd_full    = cmd_full_s;
  assign p0_cmd_empty   = cmd_empty_s;
  assign p0_cmd_error   = cmd_error_q;
  assign p0_wr_full     = wr_full_s;
  assign p0_wr_empty    = wr_empty_s;
  assign p0_wr_count    = wr_cnt_q;
  assign p0_wr_error    = wr_error_q;
  assign p0_wr_underrun = (state_q == ST_WRITE) && wr_empty_s;
  assign p0_rd_data     = rd_empty_s ? 32'd0 : rd_mem_q[rd_rptr_q];
  assign p0_rd_empty    = rd_empty_s;
  assign p0_rd_full     = (rd_cnt_q == 7'd64);
  assign p0_rd_count    = rd_cnt_q;
  assign p0_rd_error    = rd_error_q;

endmodule

// File: tb/tb_mcb_p0_responder.sv
// Bench for mcb_p0_responder: table of single-word masked writes plus
// hand-written sequences; read data checked against a scoreboard queue.
module tb_mcb_p0_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [29:0] p0_cmd_byte_addr;
  logic [5:0]  p0_cmd_bl;
  logic        p0_cmd_full, p0_cmd_empty, p0_cmd_error;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full, p0_wr_empty, p0_wr_error, p0_wr_underrun;
  logic [6:0]  p0_wr_count;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_empty, p0_rd_full, p0_rd_error;
  logic [6:0]  p0_rd_count;

  always #5 clk = ~clk;

  mcb_p0_responder #(.ADDR_WIDTH(10), .CALIB_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_full(p0_cmd_full), .p0_cmd_empty(p0_cmd_empty), .p0_cmd_error(p0_cmd_error),
    .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
    .p0_wr_full(p0_wr_full), .p0_wr_empty(p0_wr_empty), .p0_wr_count(p0_wr_count),
    .p0_wr_error(p0_wr_error), .p0_wr_underrun(p0_wr_underrun),
    .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
    .p0_rd_full(p0_rd_full), .p0_rd_count(p0_rd_count), .p0_rd_error(p0_rd_error)
  );

  typedef struct {
    logic [29:0] wr_addr;
    logic [29:0] rd_addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] sb [$];
  logic [35:0] wq [$];
  logic [6:0]  rd_peak = 7'd0;
  logic        rd_full_seen = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (p0_rd_count > rd_peak) rd_peak = p0_rd_count;
    if (p0_rd_full) rd_full_seen = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_calib_done"}, calib_done, 0);
    chk({tag, "_cmd_full"}, p0_cmd_full, 1);
    chk({tag, "_cmd_empty"}, p0_cmd_empty, 1);
    chk({tag, "_wr_empty"}, p0_wr_empty, 1);
    chk({tag, "_rd_empty"}, p0_rd_empty, 1);
    chk({tag, "_wr_full"}, p0_wr_full, 0);
    chk({tag, "_rd_full"}, p0_rd_full, 0);
    chk({tag, "_wr_count"}, p0_wr_count, 0);
    chk({tag, "_rd_count"}, p0_rd_count, 0);
    chk({tag, "_rd_data"}, p0_rd_data, 0);
    chk({tag, "_errors"}, {p0_cmd_error, p0_wr_error, p0_rd_error, p0_wr_underrun}, 0);
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    p0_wr_en = 1'b1; p0_wr_data = d; p0_wr_mask = m;
    tick();
    p0_wr_en = 1'b0;
    wq.push_back({m, d});
  endtask

  task automatic send_cmd(input logic [2:0] instr, input logic [29:0] addr, input logic [5:0] bl);
    int t = 0;
    while (p0_cmd_full && t < 200) begin tick(); t++; end
    if (p0_cmd_full) begin
      fail_timeout("cmd_ready");
      return;
    end
    p0_cmd_en = 1'b1; p0_cmd_instr = instr; p0_cmd_byte_addr = addr; p0_cmd_bl = bl;
    tick();
    p0_cmd_en = 1'b0;
  endtask

  // Apply the next n queued write words to the reference memory
  task automatic apply_words(input logic [29:0] addr, input int n);
    logic [9:0]  idx;
    logic [35:0] w;
    idx = addr[11:2];
    for (int i = 0; i < n; i++) begin
      w = wq.pop_front();
      for (int b = 0; b < 4; b++) if (!w[32+b]) model_mem[idx][8*b +: 8] = w[8*b +: 8];
      idx = idx + 10'd1;
    end
  endtask

  task automatic push_exp(input logic [29:0] addr, input int n);
    logic [9:0] idx;
    idx = addr[11:2];
    for (int i = 0; i < n; i++) begin
      sb.push_back(model_mem[idx]);
      idx = idx + 10'd1;
    end
  endtask

  task automatic write_cmd(input logic [29:0] addr, input logic [5:0] bl);
    send_cmd(3'b000, addr, bl);
    apply_words(addr, int'(bl) + 1);
  endtask

  task automatic read_cmd(input logic [29:0] addr, input logic [5:0] bl);
    send_cmd(3'b001, addr, bl);
    push_exp(addr, int'(bl) + 1);
  endtask

  // Pop n words, comparing each against the scoreboard head
  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (p0_rd_empty && t < 400) begin tick(); t++; end
      if (p0_rd_empty) begin
        fail_timeout("rd_data_wait");
        return;
      end
      if (sb.size() == 0) begin
        chk("rd_unexpected_word", p0_rd_data, 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", p0_rd_data, sb.pop_front());
      end
      p0_rd_en = 1'b1;
      tick();
      p0_rd_en = 1'b0;
    end
  endtask

  task automatic wait_rd_count(input logic [6:0] target, input string name);
    int t = 0;
    while (p0_rd_count != target && t < 400) begin tick(); t++; end
    if (p0_rd_count != target) fail_timeout(name);
  endtask

  task automatic wait_underrun(input string name);
    int t = 0;
    while (!p0_wr_underrun && t < 50) begin tick(); t++; end
    if (!p0_wr_underrun) fail_timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{30'h040,       30'h040, 32'hAABBCCDD, 4'b0000, 32'hAABBCCDD};
    vecs[1] = '{30'h040,       30'h040, 32'h11223344, 4'b0101, 32'h11BB33DD};
    vecs[2] = '{30'h083,       30'h080, 32'h12345678, 4'b0000, 32'h12345678};
    vecs[3] = '{30'h080,       30'h080, 32'hFFFFFFFF, 4'b1111, 32'h12345678};
    vecs[4] = '{30'h2000_0100, 30'h100, 32'hDEADBEEF, 4'b0000, 32'hDEADBEEF};
    vecs[5] = '{30'h100,       30'h100, 32'h00000000, 4'b1000, 32'hDE000000};

    reset_n = 1'b0;
    p0_cmd_en = 1'b0; p0_cmd_instr = 3'd0; p0_cmd_byte_addr = 30'd0; p0_cmd_bl = 6'd0;
    p0_wr_en = 1'b0; p0_wr_data = 32'd0; p0_wr_mask = 4'd0; p0_rd_en = 1'b0;

    // Reset and calibration timing, with a refused command and an early write word
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 5) begin
        p0_cmd_en = 1'b1; p0_cmd_instr = 3'b001; p0_cmd_byte_addr = 30'd0; p0_cmd_bl = 6'd0;
      end
      if (k == 7) begin
        p0_wr_en = 1'b1; p0_wr_data = 32'd0; p0_wr_mask = 4'd0;
      end
      tick();
      p0_cmd_en = 1'b0;
      p0_wr_en  = 1'b0;
      chk($sformatf("calib_done_edge%0d", k), calib_done, (k >= 16) ? 1 : 0);
      chk($sformatf("cmd_full_edge%0d", k), p0_cmd_full, (k >= 16) ? 0 : 1);
      if (k == 5) begin
        chk("cmd_error_precal", p0_cmd_error, 1);
        chk("cmd_empty_precal", p0_cmd_empty, 1);
      end
      if (k == 6) chk("cmd_error_clear", p0_cmd_error, 0);
      if (k == 7) begin
        chk("wr_count_precal", p0_wr_count, 1);
        wq.push_back({4'b0000, 32'd0});
      end
    end

    // 32-word write then read-back
    for (int i = 1; i < 32; i++) push_wr(i, 4'b0000);
    chk("wr_count_32", p0_wr_count, 32);
    write_cmd(30'h0, 6'd31);
    read_cmd(30'h0, 6'd31);
    rd_peak = 7'd0;
    wait_rd_count(7'd32, "rd_count_32");
    repeat (3) tick();
    chk("rd_peak_32", rd_peak, 32);
    chk("rd_full_at_32", p0_rd_full, 0);
    read_words(32);

    // First-word latency and back-to-back delivery
    repeat (5) tick();
    read_cmd(30'h4, 6'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("latency_empty_N+%0d", j), p0_rd_empty, 1);
    end
    tick();
    chk("latency_empty_N+4", p0_rd_empty, 0);
    chk("latency_data_N+4", p0_rd_data, 32'd1);
    tick();
    chk("latency_count_N+5", p0_rd_count, 2);
    read_words(2);

    // Table of single-word masked writes with constant expectations
    for (int v = 0; v < 6; v++) begin
      push_wr(vecs[v].data, vecs[v].mask);
      send_cmd(3'b000, vecs[v].wr_addr, 6'd0);
      apply_words(vecs[v].wr_addr, 1);
      send_cmd(3'b001, vecs[v].rd_addr, 6'd0);
      sb.push_back(vecs[v].exp);
      read_words(1);
    end

    // Refresh command has no effect on memory or the read path
    send_cmd(3'b100, 30'h040, 6'd5);
    read_cmd(30'h040, 6'd0);
    read_words(1);

    // Underrun: bl=3 with only two words queued
    push_wr(32'hA0A0_0000, 4'b0000);
    push_wr(32'hA0A0_0001, 4'b0000);
    send_cmd(3'b000, 30'h200, 6'd3);
    wait_underrun("underrun_rise");
    for (int j = 0; j < 5; j++) begin
      chk("underrun_held", p0_wr_underrun, 1);
      tick();
    end
    push_wr(32'hA0A0_0002, 4'b0000);
    push_wr(32'hA0A0_0003, 4'b0000);
    repeat (3) tick();
    chk("underrun_cleared", p0_wr_underrun, 0);
    apply_words(30'h200, 4);
    read_cmd(30'h200, 6'd3);
    read_words(4);

    // Address wrap at the top of memory
    push_wr(32'h0BAD_0001, 4'b0000);
    push_wr(32'h0BAD_0002, 4'b0000);
    write_cmd(30'hFFC, 6'd1);
    read_cmd(30'hFFC, 6'd1);
    read_words(2);
    send_cmd(3'b001, 30'h000, 6'd0);
    sb.push_back(32'h0BAD_0002);
    read_words(1);

    // Read backpressure with 40 unread words, plus a refused command at cmd_full
    rd_full_seen = 1'b0;
    read_cmd(30'h0, 6'd31);
    read_cmd(30'h0, 6'd7);
    wait_rd_count(7'd40, "rd_count_40");
    read_cmd(30'h0, 6'd31);
    repeat (10) tick();
    chk("bp_held_count", p0_rd_count, 40);
    for (int j = 0; j < 4; j++) send_cmd(3'b100, 30'h0, 6'd0);
    chk("bp_cmd_full", p0_cmd_full, 1);
    p0_cmd_en = 1'b1; p0_cmd_instr = 3'b001; p0_cmd_byte_addr = 30'h0; p0_cmd_bl = 6'd0;
    tick();
    p0_cmd_en = 1'b0;
    chk("bp_cmd_error", p0_cmd_error, 1);
    tick();
    chk("bp_cmd_error_clear", p0_cmd_error, 0);
    for (int k = 0; k < 8; k++) begin
      chk("bp_rd_data", p0_rd_data, sb.pop_front());
      p0_rd_en = 1'b1;
      tick();
      p0_rd_en = 1'b0;
      chk($sformatf("bp_count_pop%0d", k), p0_rd_count, 39 - k);
    end
    read_words(sb.size());
    repeat (10) tick();
    chk("bp_rd_full_never", rd_full_seen, 0);
    chk("bp_dropped_cmd_no_data", p0_rd_empty, 1);
    chk("bp_cmd_drained", p0_cmd_empty, 1);

    // Pop of an empty read FIFO
    p0_rd_en = 1'b1;
    tick();
    p0_rd_en = 1'b0;
    chk("rd_error_pulse", p0_rd_error, 1);
    tick();
    chk("rd_error_clear", p0_rd_error, 0);

    // Write FIFO overflow, then 64-word burst that fills the read FIFO
    for (int i = 0; i < 64; i++) push_wr(32'h5000_0000 + i, 4'b0000);
    chk("wr_full_64", p0_wr_full, 1);
    chk("wr_count_64", p0_wr_count, 64);
    p0_wr_en = 1'b1; p0_wr_data = 32'hBAD0_BAD0; p0_wr_mask = 4'b0000;
    tick();
    p0_wr_en = 1'b0;
    chk("wr_error_pulse", p0_wr_error, 1);
    chk("wr_count_after_drop", p0_wr_count, 64);
    tick();
    chk("wr_error_clear", p0_wr_error, 0);
    write_cmd(30'h800, 6'd63);
    read_cmd(30'h800, 6'd63);
    wait_rd_count(7'd64, "rd_count_64");
    chk("rd_full_64", p0_rd_full, 1);
    read_words(64);

    // Reset in the middle of a stalled write burst
    push_wr(32'h7000_0000, 4'b0000);
    push_wr(32'h7000_0001, 4'b0000);
    push_wr(32'h7000_0002, 4'b0000);
    send_cmd(3'b000, 30'hC00, 6'd7);
    wait_underrun("midburst_underrun");
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick();
    tick();
    reset_n = 1'b1;
    apply_words(30'hC00, 3);
    read_cmd(30'hC00, 6'd2);
    read_words(3);
    repeat (5) tick();
    chk("final_wr_underrun", p0_wr_underrun, 0);
    chk("final_rd_empty", p0_rd_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcb_p0_responder.md
MCB_P0_RESPONDER -- requirements
Module: mcb_p0_responder

Interface
REQ-001 Parameters: ADDR_WIDTH (default 10), the backing-memory word-address width giving 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameters: CALIB_CYCLES (default 16), the cycles from reset release to calib_done.
REQ-003 Parameters: FIFO depths are fixed: cmd 4 entries, wr 64 words, rd 64 words.
REQ-004 Ports: clk in 1, the single clock; all logic is rising-edge.
REQ-005 Ports: reset_n in 1, asynchronous, active-low reset.
REQ-006 Ports: calib_done out 1, calibration complete.
REQ-007 Ports: p0_cmd_en in 1; p0_cmd_instr in 3; p0_cmd_byte_addr in 30; p0_cmd_bl in 6, burst length minus 1.
REQ-008 Ports: p0_cmd_full out 1; p0_cmd_empty out 1; p0_cmd_error out 1, one-cycle pulse.
REQ-009 Ports: p0_wr_en in 1; p0_wr_data in 32; p0_wr_mask in 4; p0_wr_full out 1; p0_wr_empty out 1; p0_wr_count out 7; p0_wr_error out 1; p0_wr_underrun out 1.
REQ-010 Ports: p0_rd_en in 1; p0_rd_data out 32; p0_rd_empty out 1; p0_rd_full out 1; p0_rd_count out 7; p0_rd_error out 1.

Function
REQ-011 calib_done SHALL rise exactly CALIB_CYCLES clk edges after reset_n deasserts, then stay high until reset.
REQ-012 p0_cmd_full SHALL be 1 while calib_done=0 or the cmd FIFO holds 4 entries.
REQ-013 Commands: p0_cmd_en with p0_cmd_full=0 SHALL enqueue {instr, byte_addr, bl}; with p0_cmd_full=1 the command is dropped and p0_cmd_error pulses for 1 cycle.
REQ-014 Write data: p0_wr_en with p0_wr_full=0 SHALL enqueue {data, mask}; with p0_wr_full=1 the word is dropped and p0_wr_error pulses; wr_en is accepted before calib_done.
REQ-015 Read data: the rd FIFO is first-word-fall-through; p0_rd_data equals the head word whenever p0_rd_empty=0.
REQ-016 Read pop: p0_rd_en with p0_rd_empty=0 pops the head word; p0_rd_en with p0_rd_empty=1 is ignored and p0_rd_error pulses.
REQ-017 FIFO counts: counts are exact occupancy (0..64), and a simultaneous push+pop leaves the count unchanged.
REQ-018 Executor FSM states: IDLE, DECODE, WRITE, READ_WAIT, READ.
REQ-019 IDLE->DECODE: taken when the cmd FIFO is non-empty; the head command is popped on that edge.
REQ-020 DECODE: word pointer = byte_addr[ADDR_WIDTH+1:2] (byte_addr[1:0] ignored); remaining = bl+1.
REQ-021 DECODE: instr[2]=1 (refresh) -> IDLE; instr[0]=0 -> WRITE; instr[0]=1 -> READ_WAIT.
REQ-022 WRITE: each cycle with the wr FIFO non-empty pops one word and writes it to mem[ptr].
REQ-023 WRITE: byte i is written only if mask[i]=0 (byte0=[7:0]); then ptr+1, remaining-1.
REQ-024 WRITE: the FSM moves to IDLE after the last word.
REQ-025 WRITE: an empty wr FIFO stalls the FSM with p0_wr_underrun=1 for every stalled cycle.
REQ-026 READ_WAIT: the FSM moves to READ once rd_count + in-flight <= 64-(bl+1); the full burst never overflows the rd FIFO.
REQ-027 READ: one synchronous memory read per cycle, pushed into the rd FIFO one cycle later; READ ends after bl+1 reads, and the FSM returns to IDLE once the final push is done.
REQ-028 Latency: for an idle FSM, empty FIFOs and a read cmd accepted at edge N, the first word is visible (p0_rd_empty=0) after edge N+4; back-to-back words follow one per cycle.
REQ-029 Address arithmetic: ptr wraps modulo 2^ADDR_WIDTH; byte_addr bits above ADDR_WIDTH+1 are ignored.
REQ-030 Ordering: commands execute strictly in acceptance order; a read issued after a write to the same address returns the written data.
REQ-031 Backing memory contents are undefined after power-up and are NOT cleared by reset.

Reset
REQ-032 While reset_n=0, every FIFO SHALL be emptied and the FSM forced to IDLE.
REQ-033 Reset output values: calib_done=0; p0_cmd_full=1; p0_cmd_empty=1, p0_wr_empty=1, p0_rd_empty=1; p0_wr_full=0, p0_rd_full=0; both counts 0; p0_rd_data=0; all error/underrun pulses 0.
REQ-034 Reset assertion mid-burst SHALL abort the burst immediately; the words already written remain in memory.

Verification
REQ-035 Calibration: pulse reset_n low 3 cycles -> reset values per REQ-033; calib_done=1 after exactly 16 edges; p0_cmd_full falls on the same edge.
REQ-036 Write/read-back: push 32 words 0..31, write cmd addr 0x0 bl=31, then read cmd addr 0x0 bl=31 -> rd FIFO returns 0..31 in order and p0_rd_count peaks at 32.
REQ-037 Byte mask: write 0xAABBCCDD (mask 0000) at addr 0x40, then 0x11223344 (mask 0101) at the same addr, read back -> 0x11BB33DD.
REQ-038 Underrun: write cmd bl=3 with 2 words queued -> p0_wr_underrun=1 until 2 more words are pushed; read-back returns all 4.
REQ-039 Wrap: write cmd byte_addr=0xFFC, bl=1, ADDR_WIDTH=10 -> words land at mem[1023] and mem[0].
REQ-040 Backpressure: 40 words unread in the rd FIFO, issue read bl=31 -> FSM holds READ_WAIT until p0_rd_count<=32; p0_rd_full never asserts; simultaneous p0_cmd_en at cmd_full -> p0_cmd_error pulse and the command is dropped.
